// File: rtl/vga_capture.sv
// vga_capture: locks onto VGA sync timing and streams active-area RGB565 pixels with coordinates
module vga_capture #(
    parameter int H_TOTAL     = 1056,
    parameter int V_TOTAL     = 628,
    parameter int H_ACT_START = 215,
    parameter int H_ACT       = 800,
    parameter int V_ACT_START = 27,
    parameter int V_ACT       = 600,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [4:0]  red,
    input  logic [5:0]  green,
    input  logic [4:0]  blue,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

    localparam logic [10:0] H_END  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_OVER = 11'(H_TOTAL);
    localparam logic [10:0] HA_S   = 11'(H_ACT_START);
    localparam logic [10:0] HA_E   = 11'(H_ACT_START + H_ACT - 1);
    localparam logic [9:0]  V_END  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VA_S   = 10'(V_ACT_START);
    localparam logic [9:0]  VA_E   = 10'(V_ACT_START + V_ACT - 1);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    state_t      state, state_nxt;
    logic        h1, v1, h2, v_prev, line_open;
    logic [15:0] rgb1;
    logic [10:0] h_pos;
    logic [9:0]  line_cnt;
    logic [7:0]  good_cnt;
    logic        h_fall, fs, bad_line, bad_frame, bad, act;

    assign h_fall    = h2 & ~h1;
    assign fs        = h_fall & ~v1 & v_prev;
    // no line is open after reset, so the first h_sync fall cannot be judged
    assign bad_line  = line_open & (h_fall ? (h_pos != H_END) : (h_pos == H_OVER));
    assign bad_frame = fs & (line_cnt != V_END);
    assign bad       = bad_line | bad_frame;
    // gate on the next state so a lock loss blanks the very next output
    assign act       = (state_nxt == LOCKED) && h_pos >= HA_S && h_pos <= HA_E
                       && line_cnt >= VA_S && line_cnt <= VA_E;

    // Pin capture plus h_sync history; sync bits reset high so release cannot fake an edge
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            h1   <= 1'b1;
            v1   <= 1'b1;
            h2   <= 1'b1;
            rgb1 <= '0;
        end else begin
            h1   <= h_sync;
            v1   <= v_sync;
            h2   <= h1;
            rgb1 <= {red, green, blue};
        end

    // Line/frame position counters, restarted by h_sync fall and frame start
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            h_pos     <= '0;
            line_cnt  <= '0;
            v_prev    <= 1'b1;
            line_open <= 1'b0;
        end else begin
            h_pos <= h_fall ? 11'd0 : h_pos + {10'd0, h_pos != 11'h7ff};
            if (h_fall) begin
                line_cnt  <= fs ? 10'd0 : line_cnt + {9'd0, line_cnt != 10'h3ff};
                v_prev    <= v1;
                line_open <= 1'b1;
            end
        end

    // Lock state register
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) state <= UNLOCKED;
        else        state <= state_nxt;

    // Lock transitions; a bad result on a frame start keeps that frame from counting
    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (fs && !bad_line) state_nxt = CHECK;
            CHECK:    if (bad) state_nxt = UNLOCKED;
                      else if (fs && good_cnt + 8'd1 >= LOCK_N) state_nxt = LOCKED;
            LOCKED:   if (bad) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    // Lock status decode
    always_comb locked = (state == LOCKED);

    // Good-frame tally while checking and saturating count of lock losses
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == UNLOCKED) good_cnt <= '0;
            else if (state == CHECK && fs && !bad) good_cnt <= good_cnt + 8'd1;
            if (state == LOCKED && bad && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end

    // Registered pixel outputs, forced to zero outside the locked active area
    always_ff @(posedge sys_clk or negedge rst_n)
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= act;
            pix_data    <= act ? rgb1 : 16'd0;
            pix_x       <= act ? 10'(h_pos - HA_S) : 10'd0;
            pix_y       <= act ? line_cnt - VA_S : 10'd0;
            frame_start <= act && h_pos == HA_S && line_cnt == VA_S;
        end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: random-pixel VGA source against a line/frame level model of capture and lock
module tb_vga_capture;
    localparam int HT = 40, VT = 20, HAS = 6, HA = 24, VAS = 3, VA = 14, LF = 2, HSW = 4;
    localparam int NPIX = HA * VA;

    logic        sys_clk = 1'b0, rst_n = 1'b0, h_sync = 1'b1, v_sync = 1'b1;
    logic [4:0]  red = '0, blue = '0;
    logic [5:0]  green = '0;
    logic        pix_valid, frame_start, locked;
    logic [15:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  err_cnt;

    int errors = 0, checks = 0, vcount = 0;
    logic        m_locked, m_open, m_vprev, m_hprev;
    int          m_err, m_streak, m_lines, m_c;
    logic [37:0] exp_prev;
    logic        force_en = 1'b0;
    logic [15:0] force_px = '0;

    vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT(HA),
                  .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync),
        .red(red), .green(green), .blue(blue), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .locked(locked),
        .err_cnt(err_cnt));

    always #5 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_locked = 0; m_open = 0; m_vprev = 1; m_hprev = 1;
        m_err = 0; m_streak = 0; m_lines = 0; m_c = 0;
        exp_prev = '0;
    endtask

    // one pixel clock: drive pins, advance the model, compare outputs for the previous pin cycle
    task automatic step(input logic hs, input logic vs);
        logic [15:0] px;
        logic        is_fs, bad, act, first;
        logic [37:0] exp_now;
        px = force_en ? force_px : 16'($urandom);
        {red, green, blue} = px;
        h_sync = hs;
        v_sync = vs;
        if (m_hprev && !hs) begin
            is_fs = !vs && m_vprev;
            bad = (m_open && m_c != HT) || (is_fs && m_streak > 0 && m_lines != VT - 1);
            if (bad) begin
                if (m_locked) m_err++;
                m_locked = 0;
                m_streak = 0;
            end else if (is_fs) begin
                m_streak++;
                if (m_streak > LF) m_locked = 1;
            end
            m_lines = is_fs ? 0 : (m_lines < 1023 ? m_lines + 1 : 1023);
            m_vprev = vs;
            m_open = 1;
            m_c = 0;
        end
        m_hprev = hs;
        act = m_locked && (m_c - 1) >= HAS && (m_c - 1) <= HAS + HA - 1
              && m_lines >= VAS && m_lines <= VAS + VA - 1;
        first = (m_c - 1 == HAS) && (m_lines == VAS);
        exp_now = act ? {1'b1, first, px, 10'(m_c - 1 - HAS), 10'(m_lines - VAS)} : '0;
        if (m_c < 4000) m_c++;
        @(posedge sys_clk);
        #1;
        checks++;
        if ({pix_valid, frame_start, pix_data, pix_x, pix_y} !== exp_prev) begin
            errors++;
            $display("FAIL pixel_stream t=%0t got v=%b fs=%b d=%h x=%0d y=%0d want %h",
                     $time, pix_valid, frame_start, pix_data, pix_x, pix_y, exp_prev);
        end
        if (pix_valid === 1'b1) vcount++;
        exp_prev = exp_now;
    endtask

    task automatic run_line(input int len, input logic vs);
        for (int c = 0; c < len; c++) step(c < HSW ? 1'b0 : 1'b1, vs);
    endtask

    task automatic run_frame(input int nl, input int from);
        for (int l = from; l < nl; l++) run_line(HT, l < 2 ? 1'b0 : 1'b1);
    endtask

    task automatic relock_check(input string name);
        run_frame(VT, 0);
        run_frame(VT, 0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL %s_still_check got %b want 0", name, locked); end
        run_line(HT, 1'b0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL %s_relock got %b want 1", name, locked); end
        run_frame(VT, 1);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({pix_valid, frame_start, pix_data, pix_x, pix_y, locked, err_cnt} !== 47'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {pix_valid, frame_start, pix_data, pix_x, pix_y, locked, err_cnt});
        end
        rst_n = 1'b1;
        repeat (HT + 5) step(1'b1, 1'b1);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL idle_after_reset got locked=%b err=%0d want 0/0", locked, err_cnt);
        end
    endtask

    task automatic test_nominal();
        int v0;
        run_frame(VT, 0);
        run_frame(VT, 0);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", locked); end
        v0 = vcount;
        run_line(HT, 1'b0);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL lock_frame3 got %b want 1", locked); end
        run_frame(VT, 1);
        checks++;
        if (vcount - v0 !== NPIX) begin errors++; $display("FAIL pixels_frame3 got %0d want %0d", vcount - v0, NPIX); end
        v0 = vcount;
        run_frame(VT, 0);
        checks++;
        if (vcount - v0 !== NPIX) begin errors++; $display("FAIL pixels_frame4 got %0d want %0d", vcount - v0, NPIX); end
        checks++;
        if (err_cnt !== 8'd0) begin errors++; $display("FAIL nominal_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_first_pixel();
        run_frame(VAS, 0);
        for (int c = 0; c < HT; c++) begin
            force_en = (c == HAS + 1);
            force_px = 16'hF800;
            step(c < HSW ? 1'b0 : 1'b1, 1'b1);
            if (c == HAS + 1) begin
                checks++;
                if (pix_valid !== 1'b0) begin errors++; $display("FAIL before_first_pixel got %b want 0", pix_valid); end
            end
            if (c == HAS + 2) begin
                checks++;
                if ({pix_valid, frame_start, pix_data, pix_x, pix_y} !== {1'b1, 1'b1, 16'hF800, 10'd0, 10'd0}) begin
                    errors++;
                    $display("FAIL first_pixel got v=%b fs=%b d=%h x=%0d y=%0d want 1 1 f800 0 0",
                             pix_valid, frame_start, pix_data, pix_x, pix_y);
                end
            end
        end
        force_en = 1'b0;
        run_frame(VT, VAS + 1);
    endtask

    task automatic test_short_line();
        run_frame(5, 0);
        run_line(HT - 1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL short_line_pre got %b want 1", locked); end
        step(1'b0, 1'b1);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL short_line_unlock got locked=%b err=%0d want 0/1", locked, err_cnt);
        end
        for (int c = 2; c < HT; c++) step(c < HSW ? 1'b0 : 1'b1, 1'b1);
        run_frame(VT, 7);
        relock_check("short_line");
    endtask

    task automatic test_hsync_stuck();
        run_frame(5, 0);
        for (int c = 0; c < HT + 10; c++) begin
            step(c < HSW ? 1'b0 : 1'b1, 1'b1);
            if (c == HT + 1) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL stuck_pre got %b want 1", locked); end
            end
            if (c == HT + 2) begin
                checks++;
                if (locked !== 1'b0 || err_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL stuck_unlock got locked=%b err=%0d want 0/2", locked, err_cnt);
                end
            end
        end
        run_frame(VT, 6);
        checks++;
        if (err_cnt !== 8'd2) begin errors++; $display("FAIL stuck_single_count got %0d want 2", err_cnt); end
        relock_check("stuck");
    endtask

    task automatic test_short_frame();
        run_frame(VT - 1, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (locked !== 1'b0 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL short_frame_unlock got locked=%b err=%0d want 0/3", locked, err_cnt);
        end
        for (int c = 2; c < HT; c++) step(c < HSW ? 1'b0 : 1'b1, 1'b0);
        run_frame(VT, 1);
        relock_check("short_frame");
    endtask

    task automatic test_async_reset();
        int v0;
        run_frame(VAS + 2, 0);
        for (int c = 0; c < HAS + 10; c++) step(c < HSW ? 1'b0 : 1'b1, 1'b1);
        checks++;
        if (pix_valid !== 1'b1) begin errors++; $display("FAIL mid_line_active got %b want 1", pix_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({pix_valid, frame_start, pix_data, pix_x, pix_y, locked, err_cnt} !== 47'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0",
                     {pix_valid, frame_start, pix_data, pix_x, pix_y, locked, err_cnt});
        end
        repeat (3) step(1'b1, 1'b1);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b1);
        relock_check("after_reset");
        v0 = vcount;
        run_frame(VT, 0);
        checks++;
        if (vcount - v0 !== NPIX) begin errors++; $display("FAIL pixels_after_reset got %0d want %0d", vcount - v0, NPIX); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_first_pixel();
        test_short_line();
        test_hsync_stuck();
        test_short_frame();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
